// File: rtl/sync_debounce_bank.sv
// N-channel input conditioner: optional inversion, multi-flop synchronizer,
// saturating debounce counter and registered rise/fall pulses per channel.
module sync_debounce_bank #(
  parameter int              N_CH            = 4,
  parameter int              SYNC_STAGES     = 3,
  parameter int              DEBOUNCE_CYCLES = 8,
  parameter logic [N_CH-1:0] INVERT_MASK     = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] stable_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic            any_rise_o
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] in_c;
  logic [N_CH-1:0] sync;
  logic [N_CH-1:0] stable_d, stable_q;
  logic [N_CH-1:0] rise_d, rise_q;
  logic [N_CH-1:0] fall_d, fall_q;
  logic            any_rise_q;

  // Active-low pins are flipped here so everything downstream is active-high.
  assign in_c = btn_in ^ INVERT_MASK;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   upd;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
          cnt_q  <= '0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], in_c[gi]};
          cnt_q  <= cnt_d;
        end
      end

      assign sync[gi] = sync_q[SYNC_STAGES-1];

      // Any cycle that agrees with the stable level restarts the count.
      always_comb begin
        cnt_d = '0;
        upd   = 1'b0;
        if (sync[gi] != stable_q[gi]) begin
          if (cnt_q == CNT_LAST) begin
            upd = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      assign stable_d[gi] = upd ? sync[gi] : stable_q[gi];
      assign rise_d[gi]   = upd & sync[gi];
      assign fall_d[gi]   = upd & ~sync[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q   <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      any_rise_q <= 1'b0;
    end else begin
      stable_q   <= stable_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      any_rise_q <= |rise_d;
    end
  end

  assign stable_o   = stable_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign any_rise_o = any_rise_q;

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank: default instance, an active-low
// channel instance and a minimal-latency (2-stage, 1-cycle) instance.
module tb_sync_debounce_bank;

  logic       clk;
  logic       rst;
  logic [3:0] btn0, btn1;
  logic [0:0] btn2;
  logic [3:0] stable0, rise0, fall0;
  logic [3:0] stable1, rise1, fall1;
  logic [0:0] stable2, rise2, fall2;
  logic       any0, any1, any2;

  int         n_checks;
  int         n_errors;
  int         d1_pulses;
  logic [3:0] seen0;
  logic [7:0] pat;

  sync_debounce_bank #(.N_CH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8), .INVERT_MASK(4'b0000)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn0), .stable_o(stable0),
    .rise_o(rise0), .fall_o(fall0), .any_rise_o(any0));

  sync_debounce_bank #(.N_CH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8), .INVERT_MASK(4'b0010)) dut1 (
    .clk(clk), .rst(rst), .btn_in(btn1), .stable_o(stable1),
    .rise_o(rise1), .fall_o(fall1), .any_rise_o(any1));

  sync_debounce_bank #(.N_CH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INVERT_MASK(1'b0)) dut2 (
    .clk(clk), .rst(rst), .btn_in(btn2), .stable_o(stable2),
    .rise_o(rise2), .fall_o(fall2), .any_rise_o(any2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if ((|rise1) || (|fall1)) d1_pulses = d1_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance n edges, sampling 1 time unit after each; collect dut0 pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      seen0 = seen0 | rise0 | fall0;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    d1_pulses = 0;
    seen0     = '0;
    rst       = 1'b1;
    btn0      = 4'h0;
    btn1      = 4'b0010;
    btn2      = 1'b0;

    #12;
    check("reset_state", {stable0, rise0, fall0, any0}, 32'h0);
    tick(1);
    rst = 1'b0;

    // All channels high, qualify once so stable_o is 1 before the reset test.
    btn0 = 4'hF;
    tick(10);
    check("init_prequal_stable", stable0, 4'h0);
    tick(1);
    check("init_stable", stable0, 4'hF);

    // Asynchronous reset mid-cycle, then re-qualification from scratch.
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {stable0, rise0, fall0, any0}, 32'h0);
    tick(2);
    check("rst_held_outputs", {stable0, rise0, fall0, any0}, 32'h0);
    rst   = 1'b0;
    seen0 = '0;
    tick(10);
    check("rst_rel_stable_early", stable0, 4'h0);
    check("rst_rel_no_early_pulse", seen0, 4'h0);
    tick(1);
    check("rst_rel_stable", stable0, 4'hF);
    check("rst_rel_rise", rise0, 4'hF);
    check("rst_rel_any_rise", any0, 1'b1);
    tick(1);
    check("rst_rel_rise_one_cycle", rise0, 4'h0);
    check("rst_rel_any_one_cycle", any0, 1'b0);

    btn0 = 4'h0;
    tick(11);
    check("all_fall", fall0, 4'hF);
    check("all_fall_stable", stable0, 4'h0);
    tick(1);
    check("all_fall_one_cycle", fall0, 4'h0);

    // Clean press and release on ch0.
    btn0  = 4'b0001;
    seen0 = '0;
    tick(10);
    check("press_no_early_pulse", seen0, 4'h0);
    check("press_stable_early", stable0, 4'h0);
    tick(1);
    check("press_stable", stable0, 4'b0001);
    check("press_rise", rise0, 4'b0001);
    check("press_no_fall", fall0, 4'h0);
    tick(1);
    check("press_rise_one_cycle", rise0, 4'h0);
    btn0  = 4'h0;
    seen0 = '0;
    tick(10);
    check("release_no_early_pulse", seen0, 4'h0);
    check("release_stable_early", stable0, 4'b0001);
    tick(1);
    check("release_fall", fall0, 4'b0001);
    check("release_no_rise", rise0, 4'h0);
    check("release_stable", stable0, 4'h0);
    tick(1);
    check("release_fall_one_cycle", fall0, 4'h0);

    // Bounce on ch2: 1,1,1,1,1,0,1,1 then low.
    pat   = 8'b11111011;
    seen0 = '0;
    for (int i = 7; i >= 0; i--) begin
      btn0[2] = pat[i];
      tick(1);
    end
    btn0 = 4'h0;
    tick(12);
    check("bounce_stable", stable0, 4'h0);
    check("bounce_no_pulse", seen0, 4'h0);

    // Seven consecutive highs is one short of qualifying.
    seen0   = '0;
    btn0[2] = 1'b1;
    tick(7);
    btn0 = 4'h0;
    tick(12);
    check("seven_high_rejected", seen0, 4'h0);
    check("seven_high_stable", stable0, 4'h0);

    // Exactly eight highs qualify, then the later low produces one fall.
    seen0   = '0;
    btn0[2] = 1'b1;
    tick(8);
    btn0 = 4'h0;
    tick(2);
    check("eight_high_no_early", seen0, 4'h0);
    tick(1);
    check("eight_high_rise", rise0, 4'b0100);
    check("eight_high_stable", stable0, 4'b0100);
    tick(1);
    check("eight_high_rise_one_cycle", rise0, 4'h0);
    tick(6);
    check("eight_high_still_stable", stable0, 4'b0100);
    tick(1);
    check("eight_high_fall", fall0, 4'b0100);
    check("eight_high_fall_stable", stable0, 4'h0);

    // Simultaneous ch1 and ch3.
    btn0 = 4'b1010;
    tick(10);
    check("simul_any_early", any0, 1'b0);
    tick(1);
    check("simul_rise", rise0, 4'b1010);
    check("simul_any_rise", any0, 1'b1);
    tick(1);
    check("simul_any_one_cycle", any0, 1'b0);
    btn0 = 4'h0;
    tick(12);
    check("simul_settled", stable0, 4'h0);

    // Active-low ch1 on dut1, pin high (released) since power-on.
    check("inv_released_stable", stable1, 4'h0);
    check("inv_released_no_pulse", d1_pulses, 0);
    btn1 = 4'b0000;
    tick(10);
    check("inv_press_stable_early", stable1, 4'h0);
    tick(1);
    check("inv_press_rise", rise1, 4'b0010);
    check("inv_press_any", any1, 1'b1);
    check("inv_press_stable", stable1, 4'b0010);

    // Reset part-way through a qualification on ch0.
    btn0  = 4'b0001;
    seen0 = '0;
    tick(8);
    #2 rst = 1'b1;
    #1;
    check("midcount_rst_outputs", {stable0, rise0, fall0, any0}, 32'h0);
    check("midcount_no_pulse", seen0, 4'h0);
    tick(1);
    rst   = 1'b0;
    seen0 = '0;
    tick(10);
    check("midcount_requal_no_early", seen0, 4'h0);
    check("midcount_requal_stable_early", stable0, 4'h0);
    tick(1);
    check("midcount_requal_rise", rise0, 4'b0001);
    check("midcount_requal_stable", stable0, 4'b0001);

    // Minimal-latency instance: 2 sync stages, 1 debounce cycle.
    btn2 = 1'b1;
    tick(2);
    check("d1_stable_early", stable2, 1'b0);
    tick(1);
    check("d1_stable", stable2, 1'b1);
    check("d1_rise", rise2, 1'b1);
    check("d1_any", any2, 1'b1);
    tick(1);
    check("d1_rise_one_cycle", rise2, 1'b0);
    btn2 = 1'b0;
    tick(3);
    check("d1_fall", fall2, 1'b1);
    check("d1_fall_stable", stable2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
